// File: rtl/warp_issue_scheduler_pkg.sv
// Shared GPU definitions for the warp issue path: default warp count and
// the warp id type used by schedulers and their consumers.
package warp_issue_scheduler_pkg;

    localparam int N_WARP_DEF = 8;
    localparam int ID_W_DEF   = $clog2(N_WARP_DEF);

    typedef logic [ID_W_DEF-1:0] warp_id_t;

    // Registered issue offer presented to the downstream pipeline.
    typedef struct packed {
        logic     vld;
        warp_id_t id;
    } issue_offer_t;

endpackage

// File: rtl/warp_issue_scheduler_ctz.sv
// Trailing-zero counter: index of the lowest set bit of vec, with an
// all-zero flag. cnt is 0 when vec is zero.
module count_trail_zero #(
    parameter int W_IN = 8,
    parameter int CW   = (W_IN > 1) ? $clog2(W_IN) : 1
) (
    input  logic [W_IN-1:0] vec,
    output logic [CW-1:0]   cnt,
    output logic            all_zero
);

    // Scan from MSB down so the last hit is the lowest set bit.
    always_comb begin
        cnt      = '0;
        all_zero = 1'b1;
        for (int i = W_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                cnt      = CW'(i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler. Picks one eligible warp per cycle,
// holds the offer until accepted, and reserves the warp (busy) until its
// completion pulse comes back.
module warp_issue_scheduler
    import warp_issue_scheduler_pkg::*;
#(
    parameter int N_WARP = N_WARP_DEF,
    parameter int ID_W   = $clog2(N_WARP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_WARP-1:0] warp_ready,
    output logic              issue_valid,
    output logic [ID_W-1:0]   issue_id,
    input  logic              issue_ready,
    input  logic              done_valid,
    input  logic [ID_W-1:0]   done_id,
    output logic [N_WARP-1:0] busy_mask
);

    logic [ID_W-1:0]   ptr;
    logic [N_WARP-1:0] eligible;
    logic [N_WARP-1:0] hi_mask;
    logic [N_WARP-1:0] upper;
    logic [N_WARP-1:0] pick_vec;
    logic [ID_W-1:0]   cand;
    logic              pick_zero;
    logic              handshake;
    logic              load;
    logic              done_apply;
    logic [N_WARP-1:0] busy_nxt;

    assign eligible = warp_ready & ~busy_mask;

    // Bits at or above the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_WARP; gi++) begin : g_hi
            assign hi_mask[gi] = (ID_W'(gi) >= ptr);
        end
    endgenerate

    assign upper    = eligible & hi_mask;
    // Prefer warps at/after ptr; fall back to wrap-around search.
    assign pick_vec = (|upper) ? upper : eligible;

    count_trail_zero #(
        .W_IN (N_WARP),
        .CW   (ID_W)
    ) u_pick (
        .vec      (pick_vec),
        .cnt      (cand),
        .all_zero (pick_zero)
    );

    assign handshake = issue_valid & issue_ready;
    assign load      = (~issue_valid | handshake) & ~pick_zero;

    // A done aimed at the warp still being offered is stale; drop it so the
    // reservation of the pending offer survives.
    assign done_apply = done_valid & ~(issue_valid & (done_id == issue_id));

    // Next reservation: done clears first, load sets. They never collide
    // because a busy warp is never a candidate.
    always_comb begin
        busy_nxt = busy_mask;
        if (done_apply)
            busy_nxt[done_id] = 1'b0;
        if (load)
            busy_nxt[cand] = 1'b1;
    end

    // Offer register, round-robin pointer and reservation state.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_id    <= '0;
            ptr         <= '0;
            busy_mask   <= '0;
        end else begin
            busy_mask <= busy_nxt;
            if (load) begin
                issue_valid <= 1'b1;
                issue_id    <= cand;
                ptr         <= cand + 1'b1;
            end else if (handshake) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler with a cycle-level reference
// model and hand-computed expectations for the key scenarios.
module tb_warp_issue_scheduler;
    import warp_issue_scheduler_pkg::*;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  warp_ready;
    logic          issue_valid;
    warp_id_t      issue_id;
    logic          issue_ready;
    logic          done_valid;
    warp_id_t      done_id;
    logic [N-1:0]  busy_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    warp_issue_scheduler #(.N_WARP(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .warp_ready  (warp_ready),
        .issue_valid (issue_valid),
        .issue_id    (issue_id),
        .issue_ready (issue_ready),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .busy_mask   (busy_mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: rotating search from ptr over a plain busy array.
    bit           m_on = 1'b0;
    bit           m_valid;
    int           m_id;
    bit [N-1:0]   m_busy;
    int           m_ptr;
    bit           m_hs;
    int           m_cand;
    int           m_w;
    bit [N-1:0]   m_nb;

    always @(posedge clk) begin
        if (reset) begin
            m_on    = 1'b1;
            m_valid = 1'b0;
            m_id    = 0;
            m_busy  = '0;
            m_ptr   = 0;
        end else if (m_on) begin
            m_hs   = m_valid && issue_ready;
            m_cand = -1;
            for (int k = 0; k < N; k++) begin
                m_w = (m_ptr + k) % N;
                if (m_cand < 0 && warp_ready[m_w] && !m_busy[m_w])
                    m_cand = m_w;
            end
            m_nb = m_busy;
            if (done_valid && !(m_valid && int'(done_id) == m_id))
                m_nb[done_id] = 1'b0;
            if ((!m_valid || m_hs) && m_cand >= 0) begin
                m_valid     = 1'b1;
                m_id        = m_cand;
                m_nb[m_cand] = 1'b1;
                m_ptr       = (m_cand + 1) % N;
            end else if (m_hs) begin
                m_valid = 1'b0;
            end
            m_busy = m_nb;
        end
        #1;
        if (m_on) begin
            chk("model_issue_valid", 32'(issue_valid), 32'(m_valid));
            chk("model_busy_mask", 32'(busy_mask), 32'(m_busy));
            if (m_valid)
                chk("model_issue_id", 32'(issue_id), 32'(m_id));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        warp_ready  = '0;
        issue_ready = 1'b0;
        done_valid  = 1'b0;
        done_id     = '0;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        warp_ready  = '0;
        issue_ready = 1'b0;
        done_valid  = 1'b0;
        done_id     = '0;
        step(2);
        chk("reset_valid", 32'(issue_valid), 32'd0);
        chk("reset_id", 32'(issue_id), 32'd0);
        chk("reset_busy", 32'(busy_mask), 32'd0);

        // All warps ready, always accepted: ids 0..7 back to back.
        reset       = 1'b0;
        warp_ready  = 8'hFF;
        issue_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            step(1);
            chk("seq_valid", 32'(issue_valid), 32'd1);
            chk("seq_id", 32'(issue_id), 32'(k));
        end
        step(1);
        chk("seq_end_valid", 32'(issue_valid), 32'd0);
        chk("seq_end_busy", 32'(busy_mask), 32'hFF);

        // Bring ptr to 6, free warps 0 and 2, then wrap-around pick.
        do_reset();
        warp_ready  = 8'h3F;
        issue_ready = 1'b1;
        step(6);
        chk("pre_wrap_id", 32'(issue_id), 32'd5);
        warp_ready = '0;
        step(1);
        done_valid = 1'b1;
        done_id    = 3'd0;
        step(1);
        done_id    = 3'd2;
        step(1);
        done_valid = 1'b0;
        chk("wrap_busy", 32'(busy_mask), 32'h3A);
        chk("wrap_model_ptr", 32'(m_ptr), 32'd6);
        warp_ready = 8'b0000_0101;
        step(1);
        chk("wrap_first", 32'(issue_id), 32'd0);
        step(1);
        chk("wrap_second", 32'(issue_id), 32'd2);
        chk("wrap_model_ptr_after", 32'(m_ptr), 32'd3);
        warp_ready = '0;
        step(1);

        // Stalled offer of warp 3 is held while its ready drops.
        do_reset();
        warp_ready  = 8'h08;
        issue_ready = 1'b0;
        step(1);
        chk("hold_id0", 32'(issue_id), 32'd3);
        warp_ready = '0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("hold_valid", 32'(issue_valid), 32'd1);
            chk("hold_id", 32'(issue_id), 32'd3);
            chk("hold_busy3", 32'(busy_mask[3]), 32'd1);
        end

        // Done for the pending offer is ignored; done for idle warp is a no-op.
        do_reset();
        warp_ready  = 8'h04;
        issue_ready = 1'b0;
        step(1);
        warp_ready = '0;
        done_valid = 1'b1;
        done_id    = 3'd2;
        step(1);
        chk("stale_done_busy", 32'(busy_mask), 32'h04);
        chk("stale_done_id", 32'(issue_id), 32'd2);
        done_id = 3'd7;
        step(1);
        chk("idle_done_busy", 32'(busy_mask), 32'h04);
        chk("idle_done_valid", 32'(issue_valid), 32'd1);
        done_valid = 1'b0;

        // Done of warp 4 alongside a load of warp 5.
        do_reset();
        warp_ready  = 8'h10;
        issue_ready = 1'b1;
        step(1);
        warp_ready = '0;
        step(1);
        chk("pre_mix_busy", 32'(busy_mask), 32'h10);
        chk("pre_mix_valid", 32'(issue_valid), 32'd0);
        warp_ready = 8'h20;
        done_valid = 1'b1;
        done_id    = 3'd4;
        step(1);
        chk("mix_busy", 32'(busy_mask), 32'h20);
        chk("mix_id", 32'(issue_id), 32'd5);
        done_valid = 1'b0;
        warp_ready = '0;
        step(1);

        // Reset drops a pending offer; next pick restarts from 0.
        do_reset();
        warp_ready  = 8'h40;
        issue_ready = 1'b0;
        step(1);
        chk("pre_rst_id", 32'(issue_id), 32'd6);
        reset       = 1'b1;
        issue_ready = 1'b1;
        done_valid  = 1'b1;
        done_id     = 3'd6;
        step(1);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_id", 32'(issue_id), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        reset      = 1'b0;
        done_valid = 1'b0;
        warp_ready = 8'h82;
        step(1);
        chk("post_rst_id", 32'(issue_id), 32'd1);

        // Mixed traffic checked against the model every cycle.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            warp_ready  = 8'($urandom);
            issue_ready = ($urandom_range(0, 3) != 0);
            done_valid  = ($urandom_range(0, 1) != 0);
            done_id     = 3'($urandom_range(0, N - 1));
            step(1);
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_issue_scheduler.md
WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have parameter N_WARP, default 8, meaning the number of warps; it must be a power of 2 and at least 2.
REQ-002 SHALL have parameter ID_W, default $clog2(N_WARP), meaning the warp id width; it must not be overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port warp_ready, input, N_WARP bits: per-warp "has an instruction to issue" mask.
REQ-006 SHALL have port issue_valid, output, 1 bit: a registered issue offer is present.
REQ-007 SHALL have port issue_id, output, ID_W bits: the warp offered; meaningful only when issue_valid=1.
REQ-008 SHALL have port issue_ready, input, 1 bit: downstream accepts the offer; handshake when issue_valid and issue_ready are both 1.
REQ-009 SHALL have port done_valid, input, 1 bit: a completion pulse for one warp.
REQ-010 SHALL have port done_id, input, ID_W bits: the warp whose in-flight instruction completed.
REQ-011 SHALL have port busy_mask, output, N_WARP bits: registered per-warp reservation state.

Function
REQ-012 SHALL compute eligible = warp_ready & ~busy_mask, combinationally from current-cycle values.
REQ-013 SHALL keep a round-robin pointer ptr of ID_W bits.
REQ-014 SHALL select the candidate as the lowest set index of eligible among bits >= ptr; if no such bit exists, the lowest set index of eligible overall.
REQ-015 SHALL define a load condition: (issue_valid=0 or handshake) and eligible is nonzero.
REQ-016 On a load, SHALL register issue_valid=1 and issue_id=candidate, set busy_mask[candidate], and set ptr=candidate+1 modulo N_WARP.
REQ-017 SHALL clear issue_valid when a handshake occurs and no load occurs in the same cycle.
REQ-018 SHALL hold issue_valid, issue_id, ptr and the reservation stable while issue_valid=1 and issue_ready=0, even if warp_ready[issue_id] drops; an offer is never retracted.
REQ-019 SHALL have a latency of 1 cycle: eligible becoming nonzero at cycle t gives issue_valid=1 at t+1.
REQ-020 SHALL sustain one issue per cycle while issue_ready=1 and distinct warps are eligible.
REQ-021 On done_valid=1, SHALL clear busy_mask[done_id] in the next cycle, except when issue_valid=1 and done_id=issue_id; that done is ignored.
REQ-022 SHALL ignore a done for a warp whose busy bit is already clear; this is not an error.
REQ-023 When a done and a load in the same cycle target different warps, SHALL apply both.
REQ-024 When a done and a load target the same warp, SHALL never produce a conflict: the busy warp is ineligible, so the load cannot select it.
REQ-025 When eligible=0, SHALL leave ptr unchanged and perform no load.
REQ-026 SHALL treat the pointer wrap from N_WARP-1 to 0 as ordinary modulo arithmetic.

Reset
REQ-027 When reset=1 at a clock edge, SHALL set issue_valid=0, issue_id=0, busy_mask=0 and ptr=0, regardless of handshake or done activity.
REQ-028 A reset during a pending offer SHALL drop the offer without a handshake; the first load after reset release uses ptr=0.

Structure
REQ-029 SHALL take the warp id type (warp_id_t, ID_W bits) and the default N_WARP from the shared GPU package, not from local definitions.
REQ-030 SHALL implement the priority pick (REQ-014) with a single count_trail_zero instance (W_IN=N_WARP), fed by a mux between the masked-upper and full eligible vectors.

Verification (N_WARP=8)
REQ-031 Reset, then warp_ready=8'hFF with issue_ready=1 and no dones: SHALL issue ids 0,1,...,7 on consecutive cycles, then issue_valid=0 with busy_mask=8'hFF.
REQ-032 ptr=6, warp_ready=8'b0000_0101: SHALL issue id 0, then id 2; ptr becomes 3.
REQ-033 Offer id 3 held 4 cycles with issue_ready=0 while warp_ready[3] drops: SHALL keep issue_valid=1 and issue_id=3 throughout; busy_mask[3]=1.
REQ-034 busy_mask=8'h10, done_valid=1 with done_id=4, and a simultaneous load of id 5: next cycle SHALL give busy_mask=8'h20 and issue_id=5.
REQ-035 done_id equal to the pending, unaccepted issue_id=2: SHALL leave busy_mask[2]=1; a done for non-busy id 7: no state change.
REQ-036 Reset asserted while issue_valid=1: next cycle SHALL give all outputs 0; the next load picks the lowest eligible id starting from 0.
